// File: rtl/crc_check.sv
// Receive-side CRC checker: bit-serial MSB-first division of {data, crc} by POLY.
// Reports syndrome, error flag, recovered payload and a saturating error count.
module crc_check #(
  parameter int               DATA_W = 3,
  parameter int               CRC_W  = 4,
  parameter logic [CRC_W:0]   POLY   = 5'b10111,
  parameter int               CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CRC_W-1:0]  i_crc,
  input  logic              i_clr_cnt,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CRC_W-1:0]  o_syndrome,
  output logic              o_err,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_err_cnt
);

  localparam int SH_W   = DATA_W + CRC_W;
  localparam int STEP_W = $clog2(DATA_W + 1);
  // Generator aligned under the MSB of the shift register.
  localparam logic [SH_W-1:0] POLY_AL = {POLY, {(DATA_W-1){1'b0}}};

  typedef enum logic {IDLE, CALC} state_t;

  state_t              state, state_nxt;
  logic [SH_W-1:0]     shift, shift_step;
  logic [STEP_W-1:0]   step;
  logic [DATA_W-1:0]   data_q;
  logic [CRC_W-1:0]    syn_new;
  logic                accept, last_step;

  assign o_ready   = (state == IDLE);
  assign accept    = i_valid & o_ready;
  assign last_step = (state == CALC) && (step == STEP_W'(DATA_W));
  assign syn_new   = shift[SH_W-1 -: CRC_W];

  always_comb begin
    shift_step = (shift ^ (shift[SH_W-1] ? POLY_AL : '0)) << 1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CALC;
      CALC:    if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift      <= '0;
      step       <= '0;
      data_q     <= '0;
      o_data     <= '0;
      o_syndrome <= '0;
      o_err      <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= last_step;
      if (accept) begin
        shift  <= {i_data, i_crc};
        data_q <= i_data;
        step   <= '0;
      end else if (state == CALC && !last_step) begin
        shift <= shift_step;
        step  <= step + STEP_W'(1);
      end
      // Result registers only move on the completion edge, so they hold otherwise.
      if (last_step) begin
        o_syndrome <= syn_new;
        o_err      <= |syn_new;
        o_data     <= data_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_err_cnt <= '0;
    else if (i_clr_cnt)
      o_err_cnt <= '0;
    else if (last_step && (|syn_new) && (o_err_cnt != '1))
      o_err_cnt <= o_err_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check: hand-computed syndromes, latency, busy handling,
// counter saturation/clear and asynchronous reset mid-computation.
module tb_crc_check;
  logic       i_clk = 1'b0;
  logic       i_rst_n, i_valid, i_clr_cnt;
  logic [2:0] i_data;
  logic [3:0] i_crc;
  logic       o_ready, o_err, o_done;
  logic [2:0] o_data;
  logic [3:0] o_syndrome;
  logic [7:0] o_err_cnt;

  int total = 0, passed = 0;

  crc_check dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_crc(i_crc), .i_clr_cnt(i_clr_cnt), .o_ready(o_ready), .o_data(o_data),
    .o_syndrome(o_syndrome), .o_err(o_err), .o_done(o_done), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 20) begin
      tick();
      n++;
    end
    if (!o_ready) check("ready_wait", {31'b0, o_ready}, 32'd1);
  endtask

  // Accept one codeword, then step to the completion edge (accept + 4).
  task automatic send(input logic [2:0] d, input logic [3:0] c, input logic [3:0] syn,
                      input logic e, input bit full, input bit clr);
    wait_ready();
    i_valid = 1'b1; i_data = d; i_crc = c;
    tick();
    i_valid = 1'b0;
    if (full) check("busy_after_accept", o_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (full) check("no_early_done", o_done, 1'b0);
    end
    i_clr_cnt = clr;
    tick();
    i_clr_cnt = 1'b0;
    if (full) begin
      check("done", o_done, 1'b1);
      check("syndrome", o_syndrome, syn);
      check("err", o_err, e);
      check("data", o_data, d);
      check("ready_back", o_ready, 1'b1);
    end
  endtask

  logic [6:0] vw [3];
  logic [2:0] q [$];
  int acc, dn, low, seen;

  initial begin
    vw[0] = 7'b1011100; vw[1] = 7'b0010111; vw[2] = 7'b1110010;
    i_rst_n = 1'b0; i_valid = 1'b0; i_clr_cnt = 1'b0; i_data = '0; i_crc = '0;
    #1;
    check("rst_ready", o_ready, 1'b1);
    check("rst_done", o_done, 1'b0);
    check("rst_syn", o_syndrome, 4'h0);
    check("rst_err", o_err, 1'b0);
    check("rst_data", o_data, 3'h0);
    check("rst_cnt", o_err_cnt, 8'd0);
    tick(); tick();
    i_rst_n = 1'b1;
    tick();

    // Valid codewords
    send(3'b101, 4'b1100, 4'h0, 1'b0, 1, 0);
    send(3'b001, 4'b0111, 4'h0, 1'b0, 1, 0);
    send(3'b111, 4'b0010, 4'h0, 1'b0, 1, 0);
    check("cnt_after_valid", o_err_cnt, 8'd0);

    // Single-bit errors
    send(3'b101, 4'b1101, 4'b0001, 1'b1, 1, 0);
    check("cnt_crc_flip", o_err_cnt, 8'd1);
    send(3'b100, 4'b1100, 4'b0111, 1'b1, 1, 0);
    check("cnt_data_flip", o_err_cnt, 8'd2);
    tick();
    check("done_drops", o_done, 1'b0);
    check("syn_held", o_syndrome, 4'b0111);
    check("data_held", o_data, 3'b100);

    // All-zero word
    send(3'b000, 4'b0000, 4'h0, 1'b0, 1, 0);
    check("cnt_zero_word", o_err_cnt, 8'd2);

    // Busy: valid held high with data changing every cycle
    acc = 0; dn = 0; low = 0;
    for (int i = 0; i < 15; i++) begin
      i_valid = 1'b1;
      {i_data, i_crc} = vw[i % 3];
      if (o_ready) begin
        acc++;
        q.push_back(i_data);
      end else low++;
      tick();
      if (o_done) begin
        dn++;
        if (q.size() > 0) check("busy_data", o_data, q.pop_front());
        check("busy_syn", o_syndrome, 4'h0);
      end
    end
    i_valid = 1'b0;
    check("busy_accepts", acc, 3);
    check("busy_dones", dn, 3);
    check("busy_ready_low", low, 12);

    // Counter saturation then clear against a coincident error result
    for (int i = 0; i < 300; i++) send(3'b101, 4'b1101, 4'b0001, 1'b1, 0, 0);
    check("cnt_saturate", o_err_cnt, 8'd255);
    send(3'b101, 4'b1101, 4'b0001, 1'b1, 1, 1);
    check("cnt_clr_wins", o_err_cnt, 8'd0);
    send(3'b100, 4'b1100, 4'b0111, 1'b1, 1, 0);
    check("cnt_after_clr", o_err_cnt, 8'd1);

    // Reset two edges after accept
    wait_ready();
    i_valid = 1'b1; i_data = 3'b100; i_crc = 4'b1100;
    tick();
    i_valid = 1'b0;
    tick(); tick();
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_ready", o_ready, 1'b1);
    check("mid_rst_syn", o_syndrome, 4'h0);
    check("mid_rst_err", o_err, 1'b0);
    check("mid_rst_data", o_data, 3'h0);
    check("mid_rst_cnt", o_err_cnt, 8'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) i_rst_n = 1'b1;
      tick();
      if (o_done) seen++;
    end
    check("mid_rst_no_done", seen, 0);
    send(3'b001, 4'b0111, 4'h0, 1'b0, 1, 0);
    check("post_rst_cnt", o_err_cnt, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
